ro_puf_sequencer: RTL
=====================

Name: ro_puf_sequencer

Overview:
- Parametrised next-generation ring-oscillator PUF core. It evaluates RESP_BITS oscillator-pair comparisons in sequence from one wide challenge word and returns a multi-bit response plus a per-bit tie flag.
- Oscillator edges are synchronised into the system clock domain and counted over a fixed, cycle-exact measurement window, replacing free-running RO-clocked counters.
- Sits between the RO bank (instantiated outside; outputs enter on RoOut) and the challenge/response host logic, with a Start/Busy/Done handshake.

Parameters:
- SEL_W, 4, bits per oscillator index; bank size NUM_RO = 2**SEL_W (derived, not overridable).
- RESP_BITS, 8, comparisons (response bits) per Start.
- COUNTER_SIZE, 16, width of each edge counter; saturating.
- WINDOW, 1024, COUNT-state length in clock cycles (>=1).
- SETTLE, 16, SETTLE-state length in clock cycles (>=1); oscillators run, edges discarded.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  request evaluation; sampled only in IDLE.
- Challenge  input  RESP_BITS*2*SEL_W  pair k uses A = Challenge[2k*SEL_W +: SEL_W], B = Challenge[(2k+1)*SEL_W +: SEL_W].
- RoOut  input  NUM_RO  asynchronous RO (or prescaled RO) outputs.
- RoEnable  output  1  enable to RO bank.
- Busy  output  1  evaluation in progress.
- Done  output  1  one-cycle completion pulse.
- Response  output  RESP_BITS  bit k = result of pair k.
- Tie  output  RESP_BITS  bit k set if pair k counts were equal.

Behaviour:
- Reset (synchronous, active-high; one clock and one reset only): FSM -> IDLE. RoEnable, Busy, Done, Response, Tie, counters, bit index and synchroniser flops all 0. Reset mid-evaluation aborts at the next edge: no Done, no partial Response kept.
- States: IDLE, SETTLE, COUNT, COMPARE, DONE.
- IDLE: Start=1 latches Challenge, clears Response/Tie, sets k=0 -> SETTLE. Start=0 stays in IDLE.
- SETTLE: clear both counters; after SETTLE cycles -> COUNT.
- COUNT: increment counter A/B on each synchronised rising edge of RoOut[A]/RoOut[B]; after exactly WINDOW cycles -> COMPARE.
- COMPARE (1 cycle):
  - Response[k] = (cntA > cntB); Tie[k] = (cntA == cntB); on a tie Response[k] = 0.
  - If k == RESP_BITS-1 -> DONE; else k++ and -> SETTLE.
- DONE (1 cycle): Done=1 -> IDLE.
- Busy = 1 in SETTLE/COUNT/COMPARE. RoEnable = 1 in SETTLE/COUNT/COMPARE and stays continuous between bits.
- Start is ignored while Busy or Done is high; Challenge changes after acceptance have no effect.
- Sampling path: mux the selected RoOut bits, then a 2-flop synchroniser, then a third flop for edge detect; the edge is (sync & ~prev). The synchroniser runs in every state, but only COUNT-state edges count. Counting is exact only for RO periods > 2 clock cycles; faster sources must be prescaled upstream.
- Counters saturate at all-ones, with no wrap; two saturated counters report a tie.
- A == B: both counters see identical edges, giving Tie[k]=1 and Response[k]=0 (defined, not an error).
- Latency: Start accepted at edge 0. Done is high during cycle RESP_BITS*(SETTLE+WINDOW+1)+1 after acceptance. Response/Tie are valid from the Done cycle and held until the next accepted Start or reset.

Test Plan:
- Reset/idle: reset held 3 cycles mid-COUNT -> next cycle Busy=0, RoEnable=0, Response=0, Tie=0; no Done pulse follows.
- Basic compare (RESP_BITS=2, SETTLE=4, WINDOW=100, COUNTER_SIZE=16): RO3 period 10 clk, RO5 period 14 clk; Challenge pair0=(3,5), pair1=(5,3) -> cntA~10 vs ~7, Response=2'b01, Tie=2'b00, Done exactly 211 cycles after Start.
- Tie/same index: pair0=(6,6), pair1=(2,9) with RO2 and RO9 both period 20 and aligned -> Tie=2'b11, Response=2'b00.
- Saturation: COUNTER_SIZE=4, WINDOW=200, RO1 period 4, RO2 period 8 -> both counters reach 15, Tie[0]=1, Response[0]=0.
- Handshake: Start pulsed during Busy and during the Done cycle, with Challenge changed mid-run -> ignored; result matches the original challenge; a new Start the cycle after Done is accepted and clears Response.
- Full width: defaults with 16 ROs at distinct periods, random 64-bit challenge -> Response matches the reference model's period comparison on every bit; Done at 8*1041+1 cycles.

Source files
------------

// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF sequencer: evaluates RESP_BITS oscillator-pair races from one challenge word,
// counting synchronised RO edges over a cycle-exact window per pair.
module ro_puf_sequencer #(
    parameter int unsigned SEL_W        = 4,
    parameter int unsigned RESP_BITS    = 8,
    parameter int unsigned COUNTER_SIZE = 16,
    parameter int unsigned WINDOW       = 1024,
    parameter int unsigned SETTLE       = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         Start,
    input  logic [RESP_BITS*2*SEL_W-1:0] Challenge,
    input  logic [(2**SEL_W)-1:0]        RoOut,
    output logic                         RoEnable,
    output logic                         Busy,
    output logic                         Done,
    output logic [RESP_BITS-1:0]         Response,
    output logic [RESP_BITS-1:0]         Tie
);
    localparam int unsigned NUM_RO = 2**SEL_W;
    localparam int unsigned CH_W   = RESP_BITS*2*SEL_W;
    localparam int unsigned T_MAX  = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int unsigned T_W    = $clog2(T_MAX + 1);
    localparam int unsigned K_W    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_COMPARE,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    busy_d, done_d;
    logic [T_W-1:0]          tmr_q;
    logic [K_W-1:0]          k_q;
    logic [CH_W-1:0]         chal_q;
    logic [NUM_RO-1:0]       ro_bank;
    logic [SEL_W-1:0]        sel_a, sel_b;
    logic [2:0]              sync_a, sync_b;
    logic                    edge_a, edge_b;
    logic [COUNTER_SIZE-1:0] cnt_a, cnt_b;

    assign ro_bank = RoOut;

    // Oscillator indices of the pair currently being evaluated
    always_comb begin
        sel_a = chal_q[(32'(k_q) * 2) * SEL_W +: SEL_W];
        sel_b = chal_q[(32'(k_q) * 2 + 1) * SEL_W +: SEL_W];
    end

    // Two synchroniser stages plus one history flop per channel; free-running in all states
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[1:0], ro_bank[sel_a]};
            sync_b <= {sync_b[1:0], ro_bank[sel_b]};
        end
    end

    assign edge_a = sync_a[1] & ~sync_a[2];
    assign edge_b = sync_b[1] & ~sync_b[2];

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE:    if (Start) state_d = ST_SETTLE;
            ST_SETTLE:  if (tmr_q == T_W'(SETTLE - 1)) state_d = ST_COUNT;
            ST_COUNT:   if (tmr_q == T_W'(WINDOW - 1)) state_d = ST_COMPARE;
            ST_COMPARE: state_d = (k_q == K_W'(RESP_BITS - 1)) ? ST_DONE : ST_SETTLE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_COUNT) || (state_d == ST_COMPARE);
        done_d = (state_d == ST_DONE);
    end

    // Datapath and registered outputs; phase timer restarts on every state change
    always_ff @(posedge clock) begin
        if (reset) begin
            Busy     <= 1'b0;
            RoEnable <= 1'b0;
            Done     <= 1'b0;
            Response <= '0;
            Tie      <= '0;
            tmr_q    <= '0;
            k_q      <= '0;
            chal_q   <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
        end else begin
            Busy     <= busy_d;
            RoEnable <= busy_d;
            Done     <= done_d;
            tmr_q    <= (state_d != state_q) ? '0 : tmr_q + T_W'(1);
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        chal_q   <= Challenge;
                        Response <= '0;
                        Tie      <= '0;
                        k_q      <= '0;
                    end
                end
                ST_SETTLE: begin
                    cnt_a <= '0;
                    cnt_b <= '0;
                end
                ST_COUNT: begin
                    if (edge_a && (cnt_a != '1)) cnt_a <= cnt_a + COUNTER_SIZE'(1);
                    if (edge_b && (cnt_b != '1)) cnt_b <= cnt_b + COUNTER_SIZE'(1);
                end
                ST_COMPARE: begin
                    Response[k_q] <= (cnt_a > cnt_b);
                    Tie[k_q]      <= (cnt_a == cnt_b);
                    if (k_q != K_W'(RESP_BITS - 1)) k_q <= k_q + K_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
